// File: rtl/data_mem_responder_if.sv
// Request/response bus between the multi-cycle CPU and the data memory responder.
interface data_mem_responder_if;
  logic        mRD;
  logic        mWR;
  logic [31:0] DataAddr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        ready;
  logic        addr_err;

  modport master (
    output mRD, mWR, DataAddr, DataIn,
    input  DataOut, ready, addr_err
  );

  modport slave (
    input  mRD, mWR, DataAddr, DataIn,
    output DataOut, ready, addr_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed response latency and a one-cycle ready strobe.
// Rejected requests (misaligned, out of range, read+write) still complete, flagged by addr_err.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              valid_q,    valid_d;
  logic              is_wr_q,    is_wr_d;
  logic [IDX_W-1:0]  idx_q,      idx_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              ready_q,    ready_d;
  logic              addr_err_q, addr_err_d;
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] mem_d [DEPTH_WORDS];

  logic              req;
  logic              in_valid;
  logic [IDX_W-1:0]  in_idx;
  logic              commit;
  logic              cur_valid;
  logic              cur_wr;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] cur_wdata;

  // Decode of the live request, only meaningful in IDLE.
  always_comb begin
    req      = bus.mRD | bus.mWR;
    in_valid = (bus.DataAddr[1:0] == 2'b00)
            && (bus.DataAddr[31:2] < 30'(DEPTH_WORDS))
            && (bus.mRD ^ bus.mWR);
    in_idx   = bus.DataAddr[IDX_W+1:2];
  end

  // With zero latency the request commits on its accepting edge, so use live inputs there.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_valid = in_valid;
      cur_wr    = bus.mWR;
      cur_idx   = in_idx;
      cur_wdata = bus.DataIn;
    end else begin
      cur_valid = valid_q;
      cur_wr    = is_wr_q;
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
    end
  end

  // Next-state, latch and commit logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    is_wr_d    = is_wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    ready_d    = 1'b0;
    addr_err_d = 1'b0;
    commit     = 1'b0;
    mem_d      = mem_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          valid_d = in_valid;
          is_wr_d = bus.mWR;
          idx_d   = in_idx;
          wdata_d = bus.DataIn;
          if (LATENCY == 0) begin
            state_d = S_ACK;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Memory side effects happen on the edge entering ACK.
    if (commit) begin
      ready_d    = 1'b1;
      addr_err_d = ~cur_valid;
      if (cur_valid) begin
        if (cur_wr) begin
          mem_d[cur_idx] = cur_wdata;
        end else begin
          data_out_d = mem_q[cur_idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      is_wr_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      is_wr_q    <= is_wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      addr_err_q <= addr_err_d;
      mem_q      <= mem_d;
    end
  end

  assign bus.DataOut  = data_out_q;
  assign bus.ready    = ready_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with LATENCY=2 and one with LATENCY=0, checked against hand-computed values.
module tb_data_mem_responder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  data_mem_responder_if if2 ();
  data_mem_responder_if if0 ();

  data_mem_responder #(.DEPTH_WORDS(32), .LATENCY(2)) dut_l2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  data_mem_responder #(.DEPTH_WORDS(32), .LATENCY(0)) dut_l0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // One LATENCY=2 request: ready must be low for two sampled cycles, high on the third, low after.
  task automatic l2_txn(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] din,
                        input logic chg, input logic [31:0] chg_addr, input logic [31:0] chg_din,
                        input logic exp_err, input logic [31:0] exp_dout);
    if2.mRD      = rd;
    if2.mWR      = wr;
    if2.DataAddr = addr;
    if2.DataIn   = din;
    tick();
    chk({tag, ".ready_c1"}, 32'(if2.ready), 32'd0);
    if (chg) begin
      if2.DataAddr = chg_addr;
      if2.DataIn   = chg_din;
    end
    tick();
    chk({tag, ".ready_c2"}, 32'(if2.ready), 32'd0);
    chk({tag, ".err_wait"}, 32'(if2.addr_err), 32'd0);
    tick();
    chk({tag, ".ready_ack"}, 32'(if2.ready), 32'd1);
    chk({tag, ".err_ack"}, 32'(if2.addr_err), 32'(exp_err));
    chk({tag, ".dout"}, if2.DataOut, exp_dout);
    if2.mRD = 1'b0;
    if2.mWR = 1'b0;
    tick();
    chk({tag, ".ready_idle"}, 32'(if2.ready), 32'd0);
    chk({tag, ".err_idle"}, 32'(if2.addr_err), 32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst          = 1'b1;
    if2.mRD      = 1'b0;
    if2.mWR      = 1'b0;
    if2.DataAddr = '0;
    if2.DataIn   = '0;
    if0.mRD      = 1'b0;
    if0.mWR      = 1'b0;
    if0.DataAddr = '0;
    if0.DataIn   = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst.l2_ready", 32'(if2.ready), 32'd0);
    chk("rst.l2_err", 32'(if2.addr_err), 32'd0);
    chk("rst.l2_dout", if2.DataOut, 32'h0000_0000);
    chk("rst.l0_ready", 32'(if0.ready), 32'd0);
    chk("rst.l0_dout", if0.DataOut, 32'h0000_0000);

    // Write then read back.
    l2_txn("wr10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, 32'h0000_0000);
    l2_txn("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, '0, '0, 1'b0, 32'hDEAD_BEEF);

    // Misaligned and out-of-range requests leave DataOut untouched.
    l2_txn("rd06", 1'b1, 1'b0, 32'h06, 32'h0, 1'b0, '0, '0, 1'b1, 32'hDEAD_BEEF);
    l2_txn("rd80", 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, '0, '0, 1'b1, 32'hDEAD_BEEF);
    l2_txn("wr80", 1'b0, 1'b1, 32'h80, 32'hFFFF_FFFF, 1'b0, '0, '0, 1'b1, 32'hDEAD_BEEF);
    l2_txn("rd80b", 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, '0, '0, 1'b1, 32'hDEAD_BEEF);
    l2_txn("rd00", 1'b1, 1'b0, 32'h00, 32'h0, 1'b0, '0, '0, 1'b0, 32'h0000_0000);

    // Simultaneous read and write is rejected without touching memory.
    l2_txn("rdwr08", 1'b1, 1'b1, 32'h08, 32'h1234_5678, 1'b0, '0, '0, 1'b1, 32'h0000_0000);
    l2_txn("rd08", 1'b1, 1'b0, 32'h08, 32'h0, 1'b0, '0, '0, 1'b0, 32'h0000_0000);

    // Inputs changed during WAIT must be ignored.
    l2_txn("wr0c", 1'b0, 1'b1, 32'h0C, 32'hCAFE_F00D, 1'b1, 32'h14, 32'h1111_1111, 1'b0, 32'h0000_0000);
    l2_txn("rd14", 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, '0, '0, 1'b0, 32'h0000_0000);
    l2_txn("rd10b", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, '0, '0, 1'b0, 32'hDEAD_BEEF);
    l2_txn("rd0c", 1'b1, 1'b0, 32'h0C, 32'h0, 1'b0, '0, '0, 1'b0, 32'hCAFE_F00D);

    // Reset one cycle after accepting a write: request abandoned, rst wins over held mWR.
    if2.mWR      = 1'b1;
    if2.DataAddr = 32'h00;
    if2.DataIn   = 32'h55AA_55AA;
    tick();
    chk("rstwr.ready_c1", 32'(if2.ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("rstwr.ready_rst", 32'(if2.ready), 32'd0);
    chk("rstwr.dout_rst", if2.DataOut, 32'h0000_0000);
    if2.mWR = 1'b0;
    rst     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstwr.ready_after", 32'(if2.ready), 32'd0);
    end
    l2_txn("rd00b", 1'b1, 1'b0, 32'h00, 32'h0, 1'b0, '0, '0, 1'b0, 32'h0000_0000);
    l2_txn("rd0c_rst", 1'b1, 1'b0, 32'h0C, 32'h0, 1'b0, '0, '0, 1'b0, 32'h0000_0000);

    // LATENCY=0 with mRD held: ready on every other cycle, IDLE in between.
    if0.mRD      = 1'b1;
    if0.DataAddr = 32'h04;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("l0.ready_ack", 32'(if0.ready), 32'd1);
      chk("l0.err_ack", 32'(if0.addr_err), 32'd0);
      chk("l0.dout", if0.DataOut, 32'h0000_0000);
      tick();
      chk("l0.ready_idle", 32'(if0.ready), 32'd0);
    end
    if0.mRD = 1'b0;
    tick();

    // LATENCY=0 write then read.
    if0.mWR    = 1'b1;
    if0.DataIn = 32'hA5A5_A5A5;
    tick();
    chk("l0wr.ready", 32'(if0.ready), 32'd1);
    chk("l0wr.dout", if0.DataOut, 32'h0000_0000);
    if0.mWR = 1'b0;
    tick();
    chk("l0wr.ready_idle", 32'(if0.ready), 32'd0);
    if0.mRD = 1'b1;
    tick();
    chk("l0rd.ready", 32'(if0.ready), 32'd1);
    chk("l0rd.dout", if0.DataOut, 32'hA5A5_A5A5);
    if0.mRD = 1'b0;
    tick();
    chk("l0rd.ready_idle", 32'(if0.ready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
